hazard_stall_controller: RTL and testbench

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

---
 rtl/hazard_stall_controller.sv | 144 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// hazard_stall_controller : pipeline freeze / branch flush / load-use stall
// Revision: 1.0
// ============================================================================
module hazard_stall_controller #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_RegRs1,
    input  logic [4:0]       IF_ID_RegRs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegRd,
    input  logic             EX_Branch_Taken,
    input  logic             MEM_Req,
    input  logic             DMem_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Bubble,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [16:0]       wait_cnt_inc;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              freeze;
    logic              load_use;

    assign freeze   = (state_q != S_ABORT) && MEM_Req && !DMem_Ready;
    assign load_use = ID_EX_MemRead && (ID_EX_RegRd != 5'd0) &&
                      ((ID_EX_RegRd == IF_ID_RegRs1) || (ID_EX_RegRd == IF_ID_RegRs2));

    // Count of freeze cycles including the current one while waiting.
    assign wait_cnt_inc = {1'b0, wait_cnt_q} + 17'd1;

    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        EX_MEM_Write  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        MEM_WB_Bubble = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Write  = 1'b0;
                MEM_WB_Bubble = 1'b1;
            end else begin
                if (EX_Branch_Taken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use) begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
                if (state_q == S_ABORT) begin
                    MEM_WB_Bubble = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_RUN: begin
                if (freeze) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            S_WAIT: begin
                if (freeze) begin
                    if (wait_cnt_inc >= 17'(WAIT_TIMEOUT)) begin
                        state_d    = S_ABORT;
                        wait_cnt_d = 16'd0;
                        timeout_d  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_inc[15:0];
                    end
                end else begin
                    state_d    = S_RUN;
                    wait_cnt_d = 16'd0;
                end
            end
            S_ABORT: begin
                state_d    = S_RUN;
                wait_cnt_d = 16'd0;
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= 16'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (IF_ID_Flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign Mem_Timeout = timeout_q;
    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// tb_hazard_stall_controller : directed self-checking bench
// Revision: 1.0
// ============================================================================
module tb_hazard_stall_controller;

    localparam int C_TIMEOUT = 4;
    localparam int C_CNT_W   = 3;

    // {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble}
    localparam logic [6:0] C_NORMAL  = 7'b1111_000;
    localparam logic [6:0] C_FREEZE  = 7'b0000_001;
    localparam logic [6:0] C_BRANCH  = 7'b1111_110;
    localparam logic [6:0] C_LOADUSE = 7'b0011_010;
    localparam logic [6:0] C_ABORT   = 7'b1111_001;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] IF_ID_RegRs1, IF_ID_RegRs2, ID_EX_RegRd;
    logic ID_EX_MemRead, EX_Branch_Taken, MEM_Req, DMem_Ready;
    logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic ID_EX_Write, EX_MEM_Write, MEM_WB_Bubble, Mem_Timeout;
    logic [C_CNT_W-1:0] Stall_Count, Flush_Count;
    logic [6:0] ctrl;

    int tests_run    = 0;
    int tests_failed = 0;

    hazard_stall_controller #(
        .WAIT_TIMEOUT (C_TIMEOUT),
        .CNT_W        (C_CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_RegRs1    (IF_ID_RegRs1),
        .IF_ID_RegRs2    (IF_ID_RegRs2),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .ID_EX_RegRd     (ID_EX_RegRd),
        .EX_Branch_Taken (EX_Branch_Taken),
        .MEM_Req         (MEM_Req),
        .DMem_Ready      (DMem_Ready),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .ID_EX_Write     (ID_EX_Write),
        .EX_MEM_Write    (EX_MEM_Write),
        .MEM_WB_Bubble   (MEM_WB_Bubble),
        .Mem_Timeout     (Mem_Timeout),
        .Stall_Count     (Stall_Count),
        .Flush_Count     (Flush_Count)
    );

    always #5 clk = ~clk;

    assign ctrl = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                   IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IF_ID_RegRs1    = 5'd0;
        IF_ID_RegRs2    = 5'd0;
        ID_EX_RegRd     = 5'd0;
        ID_EX_MemRead   = 1'b0;
        EX_Branch_Taken = 1'b0;
        MEM_Req         = 1'b0;
        DMem_Ready      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset must override an active freeze and branch request.
        clear_inputs();
        rst_n           = 1'b0;
        MEM_Req         = 1'b1;
        EX_Branch_Taken = 1'b1;
        #2;
        check_val("rst_ctrl", 32'(ctrl), 32'(C_NORMAL));
        cycle();
        check_val("rst_ctrl_after_edge", 32'(ctrl), 32'(C_NORMAL));
        check_val("rst_stall_cnt", 32'(Stall_Count), 0);
        check_val("rst_flush_cnt", 32'(Flush_Count), 0);
        check_val("rst_timeout", 32'(Mem_Timeout), 0);
        clear_inputs();
        rst_n = 1'b1;
        #1;
        check_val("idle_ctrl", 32'(ctrl), 32'(C_NORMAL));
        cycle();

        // Load-use on Rs2
        ID_EX_MemRead = 1'b1;
        ID_EX_RegRd   = 5'd5;
        IF_ID_RegRs2  = 5'd5;
        #1;
        check_val("loaduse_ctrl", 32'(ctrl), 32'(C_LOADUSE));
        cycle();
        check_val("loaduse_stall_cnt", 32'(Stall_Count), 1);
        check_val("loaduse_flush_cnt", 32'(Flush_Count), 0);

        // Branch beats load-use
        EX_Branch_Taken = 1'b1;
        #1;
        check_val("branch_ctrl", 32'(ctrl), 32'(C_BRANCH));
        cycle();
        check_val("branch_flush_cnt", 32'(Flush_Count), 1);
        check_val("branch_stall_cnt", 32'(Stall_Count), 1);

        // Register 0 never stalls
        clear_inputs();
        ID_EX_MemRead = 1'b1;
        ID_EX_RegRd   = 5'd0;
        IF_ID_RegRs1  = 5'd0;
        #1;
        check_val("zero_reg_ctrl", 32'(ctrl), 32'(C_NORMAL));
        cycle();
        check_val("zero_reg_stall_cnt", 32'(Stall_Count), 1);

        // Load-use on Rs1, then the same match without a load
        clear_inputs();
        ID_EX_MemRead = 1'b1;
        ID_EX_RegRd   = 5'd7;
        IF_ID_RegRs1  = 5'd7;
        IF_ID_RegRs2  = 5'd3;
        #1;
        check_val("loaduse_rs1_ctrl", 32'(ctrl), 32'(C_LOADUSE));
        cycle();
        check_val("loaduse_rs1_stall_cnt", 32'(Stall_Count), 2);
        ID_EX_MemRead = 1'b0;
        #1;
        check_val("no_load_ctrl", 32'(ctrl), 32'(C_NORMAL));

        // Memory wait of 3 cycles; a branch during freeze is ignored
        do_reset();
        MEM_Req    = 1'b1;
        DMem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            EX_Branch_Taken = (i == 1);
            #1;
            check_val($sformatf("memwait_freeze_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            cycle();
        end
        EX_Branch_Taken = 1'b0;
        DMem_Ready      = 1'b1;
        #1;
        check_val("memwait_release_ctrl", 32'(ctrl), 32'(C_NORMAL));
        cycle();
        check_val("memwait_stall_cnt", 32'(Stall_Count), 3);
        check_val("memwait_flush_cnt", 32'(Flush_Count), 0);
        clear_inputs();
        #1;
        check_val("memwait_run_ctrl", 32'(ctrl), 32'(C_NORMAL));
        check_val("memwait_no_timeout", 32'(Mem_Timeout), 0);

        // Timeout after WAIT_TIMEOUT freeze cycles, then one ABORT cycle
        do_reset();
        MEM_Req    = 1'b1;
        DMem_Ready = 1'b0;
        for (int i = 0; i < C_TIMEOUT; i++) begin
            #1;
            check_val($sformatf("timeout_freeze_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            check_val($sformatf("timeout_pending_%0d", i), 32'(Mem_Timeout), 0);
            cycle();
        end
        check_val("timeout_flag", 32'(Mem_Timeout), 1);
        check_val("abort_ctrl", 32'(ctrl), 32'(C_ABORT));
        check_val("abort_stall_cnt", 32'(Stall_Count), 4);
        cycle();
        MEM_Req = 1'b0;
        #1;
        check_val("post_abort_ctrl", 32'(ctrl), 32'(C_NORMAL));
        check_val("post_abort_stall_cnt", 32'(Stall_Count), 4);
        for (int i = 0; i < 3; i++) cycle();
        check_val("timeout_sticky", 32'(Mem_Timeout), 1);

        // Reset in WAIT abandons the access and restarts the wait count
        MEM_Req    = 1'b1;
        DMem_Ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check_val("rst_in_wait_ctrl", 32'(ctrl), 32'(C_NORMAL));
        cycle();
        rst_n = 1'b1;
        check_val("rst_in_wait_timeout", 32'(Mem_Timeout), 0);
        check_val("rst_in_wait_stall_cnt", 32'(Stall_Count), 0);
        check_val("rst_in_wait_flush_cnt", 32'(Flush_Count), 0);
        for (int i = 0; i < C_TIMEOUT; i++) begin
            #1;
            check_val($sformatf("rewait_freeze_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            check_val($sformatf("rewait_pending_%0d", i), 32'(Mem_Timeout), 0);
            cycle();
        end
        check_val("rewait_timeout_flag", 32'(Mem_Timeout), 1);

        // Stall counter saturates at all-ones
        do_reset();
        ID_EX_MemRead = 1'b1;
        ID_EX_RegRd   = 5'd9;
        IF_ID_RegRs1  = 5'd9;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_val($sformatf("sat_stall_cnt_%0d", i), 32'(Stall_Count),
                      (i + 1 < 7) ? 32'(i + 1) : 32'd7);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
